cfa_frame_sequencer: RTL and testbench

//  Sequences addressing_logic over one or more frames. Accepts a frame config, drives start/en/rowMax/colMax,

---
 rtl/cfa_frame_sequencer_if.sv | 29 ++
 rtl/cfa_frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_cfa_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfa_frame_sequencer_if.sv
// Config handshake bundle between host and cfa_frame_sequencer.
// Host side drives the request, sequencer side returns ready.
interface cfa_frame_sequencer_if #(
  parameter int ROW_W   = 11,
  parameter int COL_W   = 11,
  parameter int FRAME_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [ROW_W-1:0]   cfg_rows;
  logic [COL_W-1:0]   cfg_cols;
  logic [FRAME_W-1:0] cfg_frames;

  modport master (
    output cfg_valid,
    output cfg_rows,
    output cfg_cols,
    output cfg_frames,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_rows,
    input  cfg_cols,
    input  cfg_frames,
    output cfg_ready
  );
endinterface

// File: rtl/cfa_frame_sequencer.sv
// Frame sequencer for addressing_logic: config latch, credit gating, error flags.
// Optional watchdog built when SEQ_WATCHDOG_EN is defined.
module cfa_frame_sequencer #(
  parameter int ROW_W       = 11,
  parameter int COL_W       = 11,
  parameter int FRAME_W     = 8,
  parameter int CREDITS     = 8,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  cfa_frame_sequencer_if.slave host,
  input  logic               abort,
  output logic               addr_start,
  output logic               addr_en,
  output logic               addr_rst,
  output logic [ROW_W-1:0]   addr_row_max,
  output logic [COL_W-1:0]   addr_col_max,
  input  logic               addr_done,
  input  logic               win_strobe,
  input  logic               out_consume,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               seq_done,
  output logic               err_cfg,
  output logic               err_count,
  output logic               err_credit,
  output logic               err_wdog
);

  localparam int CRW = $clog2(CREDITS + 1);
  localparam int CNW = ROW_W + COL_W;
  localparam logic [CRW-1:0] CRED_MAX = CRW'(CREDITS);

  if (CREDITS < 1) begin : g_bad_credits
    $error("CREDITS must be >= 1");
  end
  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [ROW_W-1:0]   rows_q;
  logic [COL_W-1:0]   cols_q;
  logic [FRAME_W-1:0] frames_q;
  logic [CNW-1:0]     win_cnt;
  logic [CNW-1:0]     win_total;
  logic [CNW-1:0]     win_expect;
  logic [CRW-1:0]     credit;

  logic cfg_fire;
  logic cfg_bad;
  logic cfg_good;
  logic kill;
  logic strobe_run;
  logic cred_up;
  logic last_frame;
  logic run_done;
  logic wdog_fire;

  assign host.cfg_ready = (state == S_IDLE) && !rst;

  assign cfg_fire = host.cfg_valid && host.cfg_ready;
  assign cfg_bad  = (host.cfg_rows == '0)
                 || (host.cfg_cols == '0)
                 || (host.cfg_frames == '0);
  assign cfg_good = cfg_fire && !cfg_bad;

  // abort and watchdog share one exit path; both are no-ops in IDLE
  assign kill = (abort || wdog_fire) && (state != S_IDLE);

  assign strobe_run = win_strobe && (state == S_RUN);
  assign cred_up    = out_consume && (state != S_IDLE);
  assign win_total  = win_cnt + CNW'(strobe_run);
  assign win_expect = CNW'(rows_q) * CNW'(cols_q);
  assign last_frame = frame_idx == (frames_q - FRAME_W'(1));
  assign run_done   = (state == S_RUN) && addr_done && !kill;

  assign addr_row_max = rows_q;
  assign addr_col_max = cols_q;
  assign busy         = state != S_IDLE;
  assign addr_en      = (state == S_RUN) && (credit != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (cfg_good) state_d = S_LOAD;
        S_LOAD:  state_d = S_RUN;
        S_RUN: begin
          if (addr_done) state_d = last_frame ? S_DRAIN : S_LOAD;
        end
        S_DRAIN: if (credit == CRED_MAX) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q     <= '0;
      cols_q     <= '0;
      frames_q   <= '0;
      frame_idx  <= '0;
      win_cnt    <= '0;
      credit     <= CRED_MAX;
      addr_start <= 1'b0;
      addr_rst   <= 1'b0;
      seq_done   <= 1'b0;
      err_cfg    <= 1'b0;
      err_count  <= 1'b0;
      err_credit <= 1'b0;
    end else begin
      addr_start <= state_d == S_LOAD;
      seq_done   <= state_d == S_DONE;
      addr_rst   <= kill;
      err_cfg    <= cfg_fire && cfg_bad;
      if (cfg_fire) begin
        rows_q   <= host.cfg_rows;
        cols_q   <= host.cfg_cols;
        frames_q <= host.cfg_frames;
      end
      if (cfg_good) begin
        frame_idx  <= '0;
        win_cnt    <= '0;
        credit     <= CRED_MAX;
        err_count  <= 1'b0;
        err_credit <= 1'b0;
      end else begin
        if (state == S_LOAD)  win_cnt <= '0;
        else if (strobe_run)  win_cnt <= win_total;
        // simultaneous strobe and consume cancel out
        if (cred_up && !strobe_run) begin
          if (credit == CRED_MAX) err_credit <= 1'b1;
          else                    credit     <= credit + CRW'(1);
        end else if (strobe_run && !cred_up) begin
          if (credit == '0) err_credit <= 1'b1;
          else              credit     <= credit - CRW'(1);
        end
        if (run_done) begin
          if (win_total != win_expect) err_count <= 1'b1;
          if (!last_frame) frame_idx <= frame_idx + FRAME_W'(1);
        end
      end
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(WDOG_CYCLES + 1);

  logic [WDW-1:0] wdog_cnt;

  assign wdog_fire = addr_en && !win_strobe
                  && (wdog_cnt == WDW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !addr_en || win_strobe) wdog_cnt <= '0;
    else                               wdog_cnt <= wdog_cnt + WDW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_good) err_wdog <= 1'b0;
    else if (wdog_fire)  err_wdog <= 1'b1;
  end
`else
  assign wdog_fire = 1'b0;
  assign err_wdog  = 1'b0;
`endif

endmodule

// File: tb/tb_cfa_frame_sequencer.sv
// Directed bench for cfa_frame_sequencer with a queue scoreboard
// for addr_start frame indices and seq_done events.
module tb_cfa_frame_sequencer;
  localparam int ROW_W       = 11;
  localparam int COL_W       = 11;
  localparam int FRAME_W     = 8;
  localparam int CREDITS     = 2;
  localparam int WDOG_CYCLES = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort = 1'b0;
  logic addr_done = 1'b0;
  logic win_strobe = 1'b0;
  logic out_consume = 1'b0;
  logic addr_start, addr_en, addr_rst, busy, seq_done;
  logic err_cfg, err_count, err_credit, err_wdog;
  logic [ROW_W-1:0]   addr_row_max;
  logic [COL_W-1:0]   addr_col_max;
  logic [FRAME_W-1:0] frame_idx;

  int npass = 0;
  int ntotal = 0;
  int exp_frame[$];
  int exp_done[$];

  cfa_frame_sequencer_if #(
    .ROW_W(ROW_W), .COL_W(COL_W), .FRAME_W(FRAME_W)
  ) bus ();

  cfa_frame_sequencer #(
    .ROW_W(ROW_W), .COL_W(COL_W), .FRAME_W(FRAME_W),
    .CREDITS(CREDITS), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host(bus),
    .abort(abort),
    .addr_start(addr_start),
    .addr_en(addr_en),
    .addr_rst(addr_rst),
    .addr_row_max(addr_row_max),
    .addr_col_max(addr_col_max),
    .addr_done(addr_done),
    .win_strobe(win_strobe),
    .out_consume(out_consume),
    .busy(busy),
    .frame_idx(frame_idx),
    .seq_done(seq_done),
    .err_cfg(err_cfg),
    .err_count(err_count),
    .err_credit(err_credit),
    .err_wdog(err_wdog)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int r, input int c, input int f);
    bus.cfg_valid  = 1'b1;
    bus.cfg_rows   = ROW_W'(r);
    bus.cfg_cols   = COL_W'(c);
    bus.cfg_frames = FRAME_W'(f);
    if (r != 0 && c != 0 && f != 0) begin
      for (int i = 0; i < f; i++) exp_frame.push_back(i);
      exp_done.push_back(f - 1);
    end
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic strobes(input int n, input logic cons);
    for (int i = 0; i < n; i++) begin
      win_strobe  = 1'b1;
      out_consume = cons;
      tick();
      win_strobe  = 1'b0;
      out_consume = 1'b0;
    end
  endtask

  task automatic consume1();
    out_consume = 1'b1;
    tick();
    out_consume = 1'b0;
  endtask

  task automatic done1();
    addr_done = 1'b1;
    tick();
    addr_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check(tag, busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (addr_start) begin
        if (exp_frame.size() == 0) check("start_unexp", addr_start, 1'b0);
        else check("start_frame", frame_idx, exp_frame.pop_front());
      end
      if (seq_done) begin
        if (exp_done.size() == 0) check("done_unexp", seq_done, 1'b0);
        else check("done_frame", frame_idx, exp_done.pop_front());
      end
    end
  end

  initial begin
    bus.cfg_valid  = 1'b0;
    bus.cfg_rows   = '0;
    bus.cfg_cols   = '0;
    bus.cfg_frames = '0;
    tick();
    tick();
    check("rst_ready", bus.cfg_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_start", addr_start, 1'b0);
    check("rst_errs", {err_cfg, err_count, err_credit, err_wdog}, 4'h0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", bus.cfg_ready, 1'b1);

    // T1: 4x4, one frame, consume every strobe
    send_cfg(4, 4, 1);
    check("t1_busy", busy, 1'b1);
    check("t1_ready_low", bus.cfg_ready, 1'b0);
    tick();
    check("t1_en", addr_en, 1'b1);
    strobes(16, 1'b1);
    done1();
    wait_idle("t1_idle");
    check("t1_errs", {err_cfg, err_count, err_credit, err_wdog}, 4'h0);

    // T2: credit exhaustion without consume
    send_cfg(4, 4, 1);
    tick();
    strobes(1, 1'b0);
    check("t2_en_1", addr_en, 1'b1);
    strobes(1, 1'b0);
    check("t2_en_0", addr_en, 1'b0);
    consume1();
    check("t2_en_back", addr_en, 1'b1);
    strobes(14, 1'b1);
    done1();
    check("t2_drain_busy", busy, 1'b1);
    check("t2_drain_en", addr_en, 1'b0);
    tick();
    check("t2_drain_hold", busy, 1'b1);
    consume1();
    wait_idle("t2_idle");
    check("t2_errs", {err_count, err_credit}, 2'b00);

    // T3: three frames of 2x3
    send_cfg(2, 3, 3);
    check("t3_rowmax", addr_row_max, 2);
    check("t3_colmax", addr_col_max, 3);
    for (int f = 0; f < 3; f++) begin
      tick();
      strobes(6, 1'b1);
      done1();
    end
    wait_idle("t3_idle");
    check("t3_frame_idx", frame_idx, 2);
    check("t3_err_count", err_count, 1'b0);

    // T4: zero rows rejected, then a valid config
    send_cfg(0, 4, 1);
    check("t4_err_cfg", err_cfg, 1'b1);
    check("t4_busy", busy, 1'b0);
    tick();
    check("t4_err_cfg_pulse", err_cfg, 1'b0);
    send_cfg(4, 4, 1);
    check("t4_accept", busy, 1'b1);
    tick();
    strobes(16, 1'b1);
    done1();
    wait_idle("t4_idle");

    // T5: short window count, strobe+consume credit neutrality
    send_cfg(4, 4, 1);
    tick();
    strobes(1, 1'b0);
    strobes(1, 1'b1);
    check("t5_both_en", addr_en, 1'b1);
    strobes(1, 1'b0);
    check("t5_credit0_en", addr_en, 1'b0);
    consume1();
    strobes(12, 1'b1);
    done1();
    check("t5_err_count", err_count, 1'b1);
    consume1();
    wait_idle("t5_idle");
    check("t5_sticky", err_count, 1'b1);
    check("t5_err_credit", err_credit, 1'b0);

    // T6: credit overflow error, abort mid-run, abort in idle
    send_cfg(4, 4, 1);
    check("t6_clear_count", err_count, 1'b0);
    tick();
    consume1();
    check("t6_err_credit", err_credit, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_done.delete();
    check("t6_addr_rst", addr_rst, 1'b1);
    check("t6_idle", busy, 1'b0);
    check("t6_ready", bus.cfg_ready, 1'b1);
    check("t6_en", addr_en, 1'b0);
    tick();
    check("t6_rst_pulse", addr_rst, 1'b0);
    check("t6_retained", err_credit, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_idle_abort", addr_rst, 1'b0);

`ifdef SEQ_WATCHDOG_EN
    send_cfg(4, 4, 1);
    check("wd_clear_credit", err_credit, 1'b0);
    tick();
    begin
      int n = 0;
      while (!addr_rst && n < 40) begin
        tick();
        n++;
      end
      check("wd_cycles", n, WDOG_CYCLES);
    end
    exp_done.delete();
    check("wd_err", err_wdog, 1'b1);
    check("wd_idle", busy, 1'b0);
    tick();
    check("wd_sticky", err_wdog, 1'b1);
`else
    send_cfg(4, 4, 1);
    check("nwd_clear_credit", err_credit, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) tick();
    check("nwd_busy", busy, 1'b1);
    check("nwd_err", err_wdog, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_done.delete();
    check("nwd_abort", busy, 1'b0);
`endif

    tick();
    check("q_frames_empty", exp_frame.size(), 0);
    check("q_done_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
